k052109_vram_sched: RTL

Time-slot scheduler for the tilemap VRAM (three 8-bit chips, 13-bit address) in the k052109 area. It divides clk_24M into 6 MHz pixel slots. Each slot has a render half, serving the scroll, map A, map B and fix fetches in PXH[2:1] order, and a CPU half. It arbitrates one pending CPU request into the CPU half and, during blanking, into the render half too. It drives RA, chip selects, output enables, write enables and the fetch-strobe sideband.

---
 rtl/k052109_pkg.sv | 30 +++
 rtl/k052109_cpu_port.sv | 58 +++++
 rtl/k052109_vram_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/k052109_pkg.sv
// Shared types for the k052109 tilemap VRAM slot scheduler.
package k052109_pkg;
  localparam logic [1:0] SLOT_SCROLL = 2'd0;
  localparam logic [1:0] SLOT_MAPA   = 2'd1;
  localparam logic [1:0] SLOT_MAPB   = 2'd2;
  localparam logic [1:0] SLOT_FIX    = 2'd3;

  localparam logic [1:0] LANE_0    = 2'd0;
  localparam logic [1:0] LANE_1    = 2'd1;
  localparam logic [1:0] LANE_2    = 2'd2;
  localparam logic [1:0] LANE_NONE = 2'd3;

  typedef enum logic [1:0] {HS_IDLE = 2'd0, HS_ACC = 2'd1, HS_DONE = 2'd2} half_st_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  lane;
    logic [12:0] a;
    logic [7:0]  din;
  } cpu_req_t;

  // chip2 shares the low byte of the read bus with chip0
  function automatic logic [7:0] lane_byte(input logic [1:0] lane, input logic [15:0] vd);
    case (lane)
      LANE_1:    return vd[15:8];
      LANE_NONE: return 8'hFF;
      default:   return vd[7:0];
    endcase
  endfunction
endpackage

// File: rtl/k052109_cpu_port.sv
// CPU side of the VRAM scheduler: request latch, per-half access state, ACK and read data.
module k052109_cpu_port
  import k052109_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk_24M,
  input  logic        RES,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_LANE,
  input  logic [12:0] CPU_A,
  input  logic [7:0]  CPU_DIN,
  input  logic [15:0] VD_IN,
  input  logic        half_open,
  output logic        active,
  output logic        second,
  output cpu_req_t    req,
  output logic        ack,
  output logic [7:0]  dout
);
  half_st_t   st;
  logic       pending, start, sample, rd_upd;
  logic [7:0] rd_byte, dout_q;

  assign start   = half_open & pending;
  assign active  = start | (st == HS_ACC);
  assign second  = (st == HS_ACC);
  assign ack     = (st == HS_DONE);
  assign rd_byte = lane_byte(req.lane, VD_IN);
  assign rd_upd  = ~req.we | (req.lane == LANE_NONE);
  // with RD_LAT=2 the sample point lands on the ACK cycle itself
  assign sample  = rd_upd & ((RD_LAT == 1) ? (st == HS_ACC) : (st == HS_DONE));
  assign dout    = (RD_LAT != 1 && sample) ? rd_byte : dout_q;

  always_ff @(posedge clk_24M) begin
    if (RES) begin
      st      <= HS_IDLE;
      pending <= 1'b0;
      req     <= '0;
      dout_q  <= 8'hFF;
    end else begin
      case (st)
        HS_IDLE: if (start) st <= HS_ACC;
        HS_ACC: begin
          st      <= HS_DONE;
          pending <= 1'b0;
        end
        default: st <= HS_IDLE;
      endcase
      if (CPU_REQ && !pending && st != HS_DONE) begin
        pending <= 1'b1;
        req     <= '{we: CPU_WE, lane: CPU_LANE, a: CPU_A, din: CPU_DIN};
      end
      if (sample) dout_q <= rd_byte;
    end
  end
endmodule

// File: rtl/k052109_vram_sched.sv
// Tilemap VRAM time-slot scheduler: 4-clk pixel slot split into a render half and a CPU half.
module k052109_vram_sched
  import k052109_pkg::*;
#(
  parameter int BLANK_BOOST = 1,
  parameter int RD_LAT      = 1
) (
  input  logic        clk_24M,
  input  logic        RES,
  input  logic [1:0]  PXH,
  input  logic        BLANK,
  input  logic        RENDER_EN,
  input  logic [12:0] SCROLL_ADDR,
  input  logic [12:0] MAPA_ADDR,
  input  logic [12:0] MAPB_ADDR,
  input  logic [12:0] FIX_ADDR,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_LANE,
  input  logic [12:0] CPU_A,
  input  logic [7:0]  CPU_DIN,
  input  logic [15:0] VD_IN,
  output logic        CE_6M,
  output logic        nCPU_ACCESS,
  output logic [12:0] RA,
  output logic [1:0]  RCS,
  output logic [2:0]  ROE,
  output logic [2:0]  RWE,
  output logic [7:0]  VD_OUT,
  output logic        FETCH_STB,
  output logic [1:0]  FETCH_SLOT,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_DOUT,
  output logic        CPU_WAIT
);
  logic [1:0]  ph, pxh_q, sel;
  logic        render_q, render_now, is_render, half_open;
  logic        active, second, ack;
  logic [7:0]  dout;
  logic [2:0]  lane_oh;
  logic [12:0] rnd_addr;
  cpu_req_t    req;

  assign render_now = RENDER_EN & ~(BLANK & (BLANK_BOOST != 0));
  // ph0 decides from live inputs; ph1 reuses the copy latched at ph0
  assign is_render  = (ph == 2'd0) ? render_now : (ph == 2'd1) & render_q;
  assign sel        = (ph == 2'd0) ? PXH : pxh_q;
  assign half_open  = ~ph[0] & ~is_render;
  assign lane_oh    = (req.lane == LANE_NONE) ? 3'b000 : (3'b001 << req.lane);
  assign FETCH_SLOT = pxh_q;
  assign CPU_WAIT   = CPU_REQ & ~CPU_ACK;

  always_ff @(posedge clk_24M) begin
    if (RES) begin
      ph       <= 2'd0;
      pxh_q    <= 2'd0;
      render_q <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd0) begin
        pxh_q    <= PXH;
        render_q <= render_now;
      end
    end
  end

  always_comb begin
    case (sel)
      SLOT_SCROLL: rnd_addr = SCROLL_ADDR;
      SLOT_MAPA:   rnd_addr = MAPA_ADDR;
      SLOT_MAPB:   rnd_addr = MAPB_ADDR;
      default:     rnd_addr = FIX_ADDR;
    endcase
  end

  k052109_cpu_port #(.RD_LAT(RD_LAT)) u_cpu (
    .clk_24M(clk_24M), .RES(RES), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE),
    .CPU_LANE(CPU_LANE), .CPU_A(CPU_A), .CPU_DIN(CPU_DIN), .VD_IN(VD_IN),
    .half_open(half_open), .active(active), .second(second), .req(req),
    .ack(ack), .dout(dout)
  );

  // reset forces every strobe inactive in the same cycle, so an aborted write never lands
  always_comb begin
    CE_6M       = 1'b0;
    nCPU_ACCESS = 1'b1;
    RA          = '0;
    RCS         = 2'b11;
    ROE         = 3'b111;
    RWE         = 3'b111;
    VD_OUT      = '0;
    FETCH_STB   = 1'b0;
    CPU_ACK     = 1'b0;
    CPU_DOUT    = 8'hFF;
    if (!RES) begin
      CE_6M     = (ph == 2'd3);
      FETCH_STB = render_q && (ph == 2'(RD_LAT));
      CPU_ACK   = ack;
      CPU_DOUT  = dout;
      if (is_render) begin
        RA  = rnd_addr;
        RCS = 2'b00;
        ROE = 3'b100;
      end else if (active) begin
        nCPU_ACCESS = 1'b0;
        RA          = req.a;
        RCS         = ~lane_oh[1:0];
        if (req.we) begin
          VD_OUT = req.din;
          if (second) RWE = ~lane_oh;
        end else begin
          ROE = ~lane_oh;
        end
      end
    end
  end
endmodule
